// File: rtl/mips789_defs.sv
// Shared MIPS789 definitions: interrupt controller state codes and register map.
package mips789_defs;

  localparam int IC_NSRC  = 8;
  localparam int IC_VEC_W = 3;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_SERV = 2'd2,
    IC_DONE = 2'd3
  } ic_state_e;

  localparam logic [1:0] IC_ADDR_MASK = 2'd0;
  localparam logic [1:0] IC_ADDR_PEND = 2'd1;
  localparam logic [1:0] IC_ADDR_VEC  = 2'd2;
  localparam logic [1:0] IC_ADDR_STAT = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// 8-to-3 priority encoder: lowest set index wins, vld_o flags a non-empty input.
module irq_prio_enc
  import mips789_defs::*;
(
  input  logic [IC_NSRC-1:0]  req_i,
  output logic [IC_VEC_W-1:0] idx_o,
  output logic                vld_o
);

  // Scan from the top so the last hit, the lowest index, is kept.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = IC_NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IC_VEC_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: MASK/PEND/VEC/STAT registers, priority select, irq/iack handshake FSM.
// Define INT_CTRL_EDGE_EN for rising-edge capture with W1C; default build is level-sensitive.
module int_ctrl
  import mips789_defs::*;
#(
  parameter int NSRC = IC_NSRC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSRC-1:0]     irq_src,
  input  logic                wr_en,
  input  logic [1:0]          addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  input  logic                iack,
  output logic                irq,
  output logic [IC_VEC_W-1:0] irq_vec
);

  ic_state_e             state_q;
  logic                  irq_q;
  logic [IC_VEC_W-1:0]   irq_vec_q;
  logic [NSRC-1:0]       mask_q;
  logic [NSRC-1:0]       pend_q;
  logic [NSRC-1:0]       pend_d;
  logic [NSRC-1:0]       cand;
  logic [IC_VEC_W-1:0]   win_idx;
  logic                  win_vld;
  logic                  unused_wr_hi;

  assign unused_wr_hi = ^wr_data[31:NSRC];

`ifdef INT_CTRL_EDGE_EN
  logic [NSRC-1:0] hist_q;
  logic [NSRC-1:0] clr;

  always_comb begin
    clr = '0;
    if (wr_en && addr == IC_ADDR_PEND) clr = wr_data[NSRC-1:0];
    if (state_q == IC_DONE) clr[irq_vec_q] = 1'b1;
  end

  // A fresh edge overrides any clear aimed at the same bit.
  assign pend_d = (pend_q & ~clr) | (irq_src & ~hist_q);

  always_ff @(posedge clk) begin
    if (!rst) hist_q <= '0;
    else      hist_q <= irq_src;
  end
`else
  assign pend_d = irq_src;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      if (wr_en && addr == IC_ADDR_MASK) mask_q <= wr_data[NSRC-1:0];
      pend_q <= pend_d;
    end
  end

  assign cand = pend_q & mask_q;

  irq_prio_enc u_prio (
    .req_i (cand),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // An acknowledge in REQ takes precedence over the candidate set emptying:
  // the core has already committed to the vector it saw.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IC_IDLE;
      irq_q     <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (win_vld && !iack) begin
            state_q   <= IC_REQ;
            irq_q     <= 1'b1;
            irq_vec_q <= win_idx;
          end
        end
        IC_REQ: begin
          if (iack) begin
            state_q <= IC_SERV;
            irq_q   <= 1'b0;
          end else if (!win_vld) begin
            state_q <= IC_IDLE;
            irq_q   <= 1'b0;
          end else begin
            irq_vec_q <= win_idx;
          end
        end
        IC_SERV: begin
          if (!iack) state_q <= IC_DONE;
        end
        IC_DONE: begin
          state_q <= IC_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      IC_ADDR_MASK: rd_data[NSRC-1:0]     = mask_q;
      IC_ADDR_PEND: rd_data[NSRC-1:0]     = pend_q;
      IC_ADDR_VEC:  rd_data[IC_VEC_W-1:0] = irq_vec_q;
      IC_ADDR_STAT: rd_data[1:0]          = state_q;
    endcase
  end

  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_int_ctrl;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic [7:0]  irq_src = 8'h00;
  logic        wr_en   = 1'b0;
  logic [1:0]  addr    = 2'd0;
  logic [31:0] wr_data = 32'h0;
  logic        iack    = 1'b0;
  logic [31:0] rd_data;
  logic        irq;
  logic [2:0]  irq_vec;

  int tests = 0;
  int fails = 0;

  // Reference model state: state codes 0 IDLE, 1 REQ, 2 SERV, 3 DONE
  logic [7:0] m_mask = 8'h00;
  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_prev = 8'h00;
  int         m_state = 0;
  logic       m_irq = 1'b0;
  logic [2:0] m_vec = 3'd0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .iack    (iack),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_mask};
      2'd1:    return {24'h0, m_pend};
      2'd2:    return {29'h0, m_vec};
      default: return 32'(m_state);
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] cand;
    logic [7:0] npend;
    logic [7:0] clr;
    int         w;
    if (!rst) begin
      m_mask = 0; m_pend = 0; m_prev = 0; m_state = 0; m_irq = 0; m_vec = 0;
      return;
    end
    cand = m_pend & m_mask;
    w    = lowest(cand);
`ifdef INT_CTRL_EDGE_EN
    clr = (wr_en && addr == 2'd1) ? wr_data[7:0] : 8'h00;
    if (m_state == 3) clr[m_vec] = 1'b1;
    npend  = (m_pend & ~clr) | (irq_src & ~m_prev);
    m_prev = irq_src;
`else
    clr   = 8'h00;
    npend = irq_src | clr;
`endif
    if (wr_en && addr == 2'd0) m_mask = wr_data[7:0];
    case (m_state)
      0: if (w >= 0 && !iack) begin m_state = 1; m_irq = 1; m_vec = w[2:0]; end
      1: begin
        if (iack)        begin m_state = 2; m_irq = 0; end
        else if (w < 0)  begin m_state = 0; m_irq = 0; end
        else             m_vec = w[2:0];
      end
      2: if (!iack) m_state = 3;
      default: m_state = 0;
    endcase
    m_pend = npend;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    check("irq_vec", {29'h0, irq_vec}, {29'h0, m_vec});
    check("rd_data", rd_data, m_read(addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic serve();
    iack = 1'b1; tick();
    iack = 1'b0; tick(); tick();
  endtask

  initial begin
    rst = 1'b0;
    tick();
    check("rst_irq", {31'h0, irq}, 32'h0);
    rdchk("rst_mask", 2'd0, 32'h0);
    rdchk("rst_stat", 2'd3, 32'h0);
    rst = 1'b1;
    tick();

`ifdef INT_CTRL_EDGE_EN
    wr(2'd0, 32'hFF);
    irq_src = 8'h20; tick(); irq_src = 8'h00;
    rdchk("pend_sample", 2'd1, 32'h20);
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    tick();
    check("irq_rise", {31'h0, irq}, 32'h1);
    check("vec5", {29'h0, irq_vec}, 32'd5);
    iack = 1'b1; tick();
    check("irq_ack_drop", {31'h0, irq}, 32'h0);
    rdchk("stat_serv", 2'd3, 32'd2);
    iack = 1'b0; tick();
    rdchk("stat_done", 2'd3, 32'd3);
    tick();
    rdchk("pend_cleared", 2'd1, 32'h0);
    rdchk("stat_idle", 2'd3, 32'd0);

    irq_src = 8'h40; tick(); irq_src = 8'h00; tick();
    check("vec6", {29'h0, irq_vec}, 32'd6);
    irq_src = 8'h04; tick(); irq_src = 8'h00; tick();
    check("vec_track2", {29'h0, irq_vec}, 32'd2);
    iack = 1'b1; tick();
    check("vec_latch2", {29'h0, irq_vec}, 32'd2);
    iack = 1'b0; tick(); tick();
    rdchk("pend_left6", 2'd1, 32'h40);
    tick();
    check("irq_re6", {31'h0, irq}, 32'h1);
    check("vec_re6", {29'h0, irq_vec}, 32'd6);
    serve();

    irq_src = 8'h08; tick(); irq_src = 8'h00; tick();
    check("vec3", {29'h0, irq_vec}, 32'd3);
    wr(2'd0, 32'hF7); tick();
    check("irq_masked", {31'h0, irq}, 32'h0);
    rdchk("stat_masked", 2'd3, 32'd0);
    rdchk("pend3_kept", 2'd1, 32'h08);
    wr(2'd0, 32'hFF); tick();
    check("irq_unmask", {31'h0, irq}, 32'h1);
    check("vec3_again", {29'h0, irq_vec}, 32'd3);
    serve();

    irq_src = 8'h10; tick(); irq_src = 8'h00; tick();
    iack = 1'b1; tick();
    irq_src = 8'h01; tick(); irq_src = 8'h00; tick();
    check("irq_held_serv", {31'h0, irq}, 32'h0);
    rdchk("pend0_in_serv", 2'd1, 32'h11);
    iack = 1'b0; tick(); tick();
    check("irq_low_after_done", {31'h0, irq}, 32'h0);
    tick();
    check("irq_src0", {31'h0, irq}, 32'h1);
    check("vec0", {29'h0, irq_vec}, 32'd0);
    wr(2'd1, 32'h01);
    rdchk("w1c_clear", 2'd1, 32'h0);
    irq_src = 8'h01;
    wr(2'd1, 32'h01);
    irq_src = 8'h00;
    rdchk("set_wins", 2'd1, 32'h01);
    tick(); serve();

    iack = 1'b1; irq_src = 8'h02; tick(); irq_src = 8'h00; tick(); tick();
    check("stale_block", {31'h0, irq}, 32'h0);
    iack = 1'b0; tick();
    check("stale_release", {31'h0, irq}, 32'h1);
    check("vec1", {29'h0, irq_vec}, 32'd1);
    serve();

    irq_src = 8'h20; tick(); irq_src = 8'h00; tick();
    iack = 1'b1; tick();
    rst = 1'b0; tick(); rst = 1'b1; iack = 1'b0;
    rdchk("rst_mid_stat", 2'd3, 32'd0);
    rdchk("rst_mid_pend", 2'd1, 32'h0);
    rdchk("rst_mid_mask", 2'd0, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    check("rst_mid_vec", {29'h0, irq_vec}, 32'd0);
`else
    wr(2'd0, 32'hFF);
    irq_src = 8'h02; tick();
    rdchk("lvl_pend", 2'd1, 32'h02);
    tick();
    check("lvl_irq", {31'h0, irq}, 32'h1);
    check("lvl_vec1", {29'h0, irq_vec}, 32'd1);
    wr(2'd1, 32'h02);
    rdchk("lvl_w1c_ignored", 2'd1, 32'h02);
    irq_src = 8'h00; tick();
    rdchk("lvl_pend_release", 2'd1, 32'h0);
    tick();
    check("lvl_irq_drop", {31'h0, irq}, 32'h0);
    rdchk("lvl_stat_idle", 2'd3, 32'd0);

    irq_src = 8'h0A; tick(); tick();
    check("lvl_prio", {29'h0, irq_vec}, 32'd1);
    iack = 1'b1; tick();
    rdchk("lvl_stat_serv", 2'd3, 32'd2);
    iack = 1'b0; tick();
    rdchk("lvl_stat_done", 2'd3, 32'd3);
    tick();
    rdchk("lvl_done_noclr", 2'd1, 32'h0A);
    tick();
    check("lvl_irq_again", {31'h0, irq}, 32'h1);
    irq_src = 8'h00; tick(); tick();

    iack = 1'b1; irq_src = 8'h80; tick(); tick();
    check("lvl_stale_block", {31'h0, irq}, 32'h0);
    iack = 1'b0; tick();
    check("lvl_stale_release", {31'h0, irq}, 32'h1);
    check("lvl_vec7", {29'h0, irq_vec}, 32'd7);
    iack = 1'b1; tick();
    rst = 1'b0; tick(); rst = 1'b1; iack = 1'b0; irq_src = 8'h00;
    rdchk("lvl_rst_stat", 2'd3, 32'd0);
    rdchk("lvl_rst_mask", 2'd0, 32'h0);
    rdchk("lvl_rst_pend", 2'd1, 32'h0);
    check("lvl_rst_irq", {31'h0, irq}, 32'h0);
    check("lvl_rst_vec", {29'h0, irq_vec}, 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom) & 8'($urandom);
      wr_en   = ($urandom_range(0, 7) == 0);
      addr    = 2'($urandom);
      wr_data = $urandom;
      if (!iack && m_irq && $urandom_range(0, 2) == 0)               iack = 1'b1;
      else if (iack && $urandom_range(0, 3) == 0)                    iack = 1'b0;
      else if (!iack && m_state == 0 && $urandom_range(0, 40) == 0)  iack = 1'b1;
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end
    wr_en = 1'b0;
    rst   = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter NSRC, default 8, meaning number of interrupt sources (fixed at 8 for this release; vector width 3).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 irq_src  input  8  external interrupt request lines, already synchronous to clk.
REQ-005 wr_en  input  1  register write strobe.
REQ-006 addr  input  2  register address for read and write.
REQ-007 wr_data  input  32  register write data.
REQ-008 rd_data  output  32  register read data, combinational from addr.
REQ-009 iack  input  1  core acknowledge; high from interrupt entry until return.
REQ-010 irq  output  1  registered interrupt request to the core control FSM.
REQ-011 irq_vec  output  3  index of the source being requested or serviced.

Function
REQ-012 Registers SHALL be: addr 0 MASK[7:0] (R/W, 1 = enabled); addr 1 PEND[7:0] (read; write-1-to-clear); addr 2 VEC (read {29'b0, irq_vec}); addr 3 STAT (read {30'b0, state code}); unused bits read 0.
REQ-013 PEND[i] SHALL set on the clock edge where the source event (see Configuration) is sampled on irq_src[i], regardless of MASK.
REQ-014 Candidate set SHALL be PEND & MASK; the winner SHALL be the lowest set index (bit 0 highest priority).
REQ-015 States SHALL be IDLE(0), REQ(1), SERV(2), DONE(3).
REQ-016 IDLE: if candidate set non-zero and iack low, go REQ; irq and irq_vec update on that same edge, so irq rises two edges after the source event is sampled.
REQ-017 REQ: irq=1; irq_vec SHALL track the current winner each cycle; if the candidate set becomes empty (mask write or W1C), go IDLE with irq=0 next cycle; on iack high, latch irq_vec, drop irq, go SERV.
REQ-018 SERV: irq=0, irq_vec frozen; new events accumulate in PEND; on iack low, go DONE.
REQ-019 DONE: one cycle, irq=0; clear PEND[irq_vec] (edge mode only), then go IDLE.
REQ-020 Simultaneous new event and clear (W1C or DONE clear) on the same PEND bit: set SHALL win.
REQ-021 iack high while in IDLE (stale acknowledge) SHALL block REQ entry until iack returns low.
REQ-022 MASK writes SHALL take effect on the next cycle's candidate set; MASK does not affect SERV.

Reset
REQ-023 With rst low at a clock edge: state=IDLE, MASK=0, PEND=0, irq=0, irq_vec=0, edge history=0; applies mid-service, discarding any in-flight interrupt.

Configuration
REQ-024 Macro INT_CTRL_EDGE_EN defined: event = rising edge (irq_src[i] high, previous sample low), PEND latched until W1C or DONE.
REQ-025 INT_CTRL_EDGE_EN undefined: level mode, PEND[i] = registered irq_src[i]; W1C and DONE clear have no effect; edge history register omitted.

Structure
REQ-026 State codes and register addresses SHALL live in the shared mips789_defs definitions file alongside existing FSM and PC control codes.
REQ-027 The 8-to-3 priority encoder SHALL be a separate combinational sub-module irq_prio_enc (inputs: 8-bit vector; outputs: 3-bit index, 1-bit valid).

Verification
REQ-028 Edge mode, MASK=0xFF, pulse irq_src[5] one cycle -> PEND=0x20, irq=1 and irq_vec=5 two edges after sample; raise iack -> irq=0, STAT=2; drop iack -> DONE, PEND=0x00, STAT=0.
REQ-029 irq_src[6] then irq_src[2] rise while in REQ -> irq_vec changes 6 to 2; iack latches 2; after DONE, irq re-asserts with irq_vec=6.
REQ-030 In REQ with vec=3, write MASK=0xF7 -> irq=0 next cycle, state IDLE, PEND[3] still set; write MASK=0xFF -> irq re-asserts, vec=3.
REQ-031 During SERV raise irq_src[0] -> irq stays 0 until after DONE, then irq=1, irq_vec=0; W1C to PEND bit 0 in same cycle as new edge -> bit stays set.
REQ-032 Assert rst low during SERV -> next edge: STAT=0, PEND=0, MASK=0, irq=0, irq_vec=0.
REQ-033 Level mode build: hold irq_src[1] high -> PEND[1]=1, W1C ignored; release -> PEND[1]=0 next cycle; irq drops if still in REQ.
